// File: rtl/clahe_hist_accum.sv
// CLAHE tile histogram accumulator: 3-stage read-modify-write into an external bin RAM
// with hazard forwarding, plus frame sequencing. Define CLAHE_HIST_SAT_EN to saturate bins.
module clahe_hist_accum #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned TILE_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic [PIX_W-1:0]  in_pix,
  input  logic              in_href,
  input  logic              in_vsync,
  input  logic [TILE_W-1:0] tile_idx,
  output logic [TILE_W-1:0] ram_rd_tile,
  output logic [PIX_W-1:0]  ram_rd_addr,
  input  logic [CNT_W-1:0]  ram_rd_data,
  output logic [TILE_W-1:0] ram_wr_tile,
  output logic [PIX_W-1:0]  ram_wr_addr,
  output logic [CNT_W-1:0]  ram_wr_data,
  output logic              ram_wr_en,
  output logic              clear_start,
  input  logic              clear_done,
  output logic              frame_hist_done,
  output logic [23:0]       frame_pix_cnt,
  output logic              frame_overrun
);

  localparam int unsigned KEY_W  = TILE_W + PIX_W;
  localparam int unsigned PCNT_W = 24;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN, ST_WAIT_CLR} state_e;

  logic              vsync_q;
  logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
  logic              w_valid_q, w_valid_d;
  logic [KEY_W-1:0]  s1_key_q, s1_key_d, s2_key_q, s2_key_d, s3_key_q, s3_key_d, w_key_q, w_key_d;
  logic [CNT_W-1:0]  s3_cnt_q, s3_cnt_d, w_cnt_q, w_cnt_d;
  logic [CNT_W-1:0]  base_c;
  logic [PCNT_W-1:0] pix_cnt_q, pix_cnt_d, snap_q, snap_d, frame_pix_cnt_q, frame_pix_cnt_d;
  state_e            state_q, state_d;
  logic [1:0]        drain_q, drain_d;
  logic              pend_q, pend_d;
  logic              overrun_q, overrun_d, done_q, done_d, clr_q, clr_d;
  logic              pix_vld_c, vs_rise_c, vs_fall_c;

  assign pix_vld_c = in_href && in_vsync;
  assign vs_rise_c = in_vsync && !vsync_q;
  assign vs_fall_c = !in_vsync && vsync_q;

  // Datapath: S1 addresses the RAM, S2 picks the freshest count, S3 holds the write.
  always_comb begin
    s1_valid_d = pix_vld_c;
    s1_key_d   = {tile_idx, in_pix};
    s2_valid_d = s1_valid_q;
    s2_key_d   = s1_key_q;
    base_c     = ram_rd_data;
    // S3 is newer than the previous-cycle write; RAM data misses both.
    if (s3_valid_q && (s3_key_q == s2_key_q)) begin
      base_c = s3_cnt_q;
    end else if (w_valid_q && (w_key_q == s2_key_q)) begin
      base_c = w_cnt_q;
    end
    s3_valid_d = s2_valid_q;
    s3_key_d   = s2_key_q;
`ifdef CLAHE_HIST_SAT_EN
    s3_cnt_d   = (base_c == {CNT_W{1'b1}}) ? base_c : base_c + CNT_W'(1);
`else
    s3_cnt_d   = base_c + CNT_W'(1);
`endif
    w_valid_d  = s3_valid_q;
    w_key_d    = s3_key_q;
    w_cnt_d    = s3_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    if (vs_rise_c) begin
      pix_cnt_d = pix_vld_c ? PCNT_W'(1) : '0;
    end else if (pix_vld_c && (pix_cnt_q != {PCNT_W{1'b1}})) begin
      pix_cnt_d = pix_cnt_q + PCNT_W'(1);
    end
  end

  // Frame sequencing; never gates accumulation.
  always_comb begin
    state_d         = state_q;
    drain_d         = drain_q;
    pend_d          = pend_q;
    overrun_d       = overrun_q;
    snap_d          = snap_q;
    frame_pix_cnt_d = frame_pix_cnt_q;
    done_d          = 1'b0;
    clr_d           = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (vs_rise_c) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (vs_fall_c) begin
          state_d = ST_DRAIN;
          drain_d = '0;
          pend_d  = 1'b0;
          snap_d  = pix_cnt_q;
        end
      end
      ST_DRAIN: begin
        if (vs_rise_c) pend_d = 1'b1;
        if (drain_q == 2'd2) begin
          done_d          = 1'b1;
          clr_d           = 1'b1;
          frame_pix_cnt_d = snap_q;
          pend_d          = 1'b0;
          state_d         = (pend_q || vs_rise_c) ? ST_ACCUM : ST_WAIT_CLR;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      ST_WAIT_CLR: begin
        if (vs_rise_c) begin
          overrun_d = 1'b1;
          state_d   = ST_ACCUM;
        end else if (clear_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q         <= 1'b0;
      s1_valid_q      <= 1'b0;
      s2_valid_q      <= 1'b0;
      s3_valid_q      <= 1'b0;
      w_valid_q       <= 1'b0;
      s1_key_q        <= '0;
      s2_key_q        <= '0;
      s3_key_q        <= '0;
      w_key_q         <= '0;
      s3_cnt_q        <= '0;
      w_cnt_q         <= '0;
      pix_cnt_q       <= '0;
      snap_q          <= '0;
      frame_pix_cnt_q <= '0;
      state_q         <= ST_IDLE;
      drain_q         <= '0;
      pend_q          <= 1'b0;
      overrun_q       <= 1'b0;
      done_q          <= 1'b0;
      clr_q           <= 1'b0;
    end else begin
      vsync_q         <= in_vsync;
      s1_valid_q      <= s1_valid_d;
      s2_valid_q      <= s2_valid_d;
      s3_valid_q      <= s3_valid_d;
      w_valid_q       <= w_valid_d;
      s1_key_q        <= s1_key_d;
      s2_key_q        <= s2_key_d;
      s3_key_q        <= s3_key_d;
      w_key_q         <= w_key_d;
      s3_cnt_q        <= s3_cnt_d;
      w_cnt_q         <= w_cnt_d;
      pix_cnt_q       <= pix_cnt_d;
      snap_q          <= snap_d;
      frame_pix_cnt_q <= frame_pix_cnt_d;
      state_q         <= state_d;
      drain_q         <= drain_d;
      pend_q          <= pend_d;
      overrun_q       <= overrun_d;
      done_q          <= done_d;
      clr_q           <= clr_d;
    end
  end

  assign ram_rd_tile     = s1_key_q[PIX_W +: TILE_W];
  assign ram_rd_addr     = s1_key_q[PIX_W-1:0];
  assign ram_wr_tile     = s3_key_q[PIX_W +: TILE_W];
  assign ram_wr_addr     = s3_key_q[PIX_W-1:0];
  assign ram_wr_data     = s3_cnt_q;
  assign ram_wr_en       = s3_valid_q;
  assign clear_start     = clr_q;
  assign frame_hist_done = done_q;
  assign frame_pix_cnt   = frame_pix_cnt_q;
  assign frame_overrun   = overrun_q;

endmodule
